uart_msg_tx: RTL and testbench

Reads a message of `msg_len` bytes from the shared byte BRAM, starting at `TXSTR_BASE`, and serializes it on the UART TX line as 8N1 frames, LSB first. It is the reader/transmit end of the message-buffer handshake. A producer writes the bytes into BRAM, then pulses `msg_valid` with `msg_len`. This block owns the BRAM port only while `busy` is high; the top-level mux grants the port accordingly.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 67 ++++++
 rtl/uart_msg_tx.sv | 110 +++++++++++
 tb/tb_uart_msg_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the message transmitter.
// UART_MSG_TX_PARITY_EN selects the 11-bit frame with an even-parity bit after D7.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

`ifdef UART_MSG_TX_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;
`else
  localparam int unsigned UART_FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } uart_tx_state_t;

  // Complete line frame, bit 0 goes out first.
  function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_DATA_W-1:0] data);
`ifdef UART_MSG_TX_PARITY_EN
    return {UART_STOP_BIT, ^data, data, UART_START_BIT};
`else
    return {UART_STOP_BIT, data, UART_START_BIT};
`endif
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer: baud counter, bit counter and frame shift register.
// Frame length follows UART_MSG_TX_PARITY_EN through uart_pkg.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [UART_DATA_W-1:0] data,
  output logic                   TX,
  output logic                   frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(UART_FRAME_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_FRAME_BITS - 1);

  logic                       r_active;
  logic [BAUD_W-1:0]          r_baud;
  logic [BIT_W-1:0]           r_bit;
  logic [UART_FRAME_BITS-1:0] r_shift;
  logic                       r_frame_done;

  // Shift register refills with stop-level ones, so the line idles high after a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active     <= 1'b0;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (start) begin
        r_active <= 1'b1;
        r_baud   <= '0;
        r_bit    <= '0;
        r_shift  <= uart_frame(data);
      end else if (r_active) begin
        if (r_baud == BAUD_LAST) begin
          r_baud  <= '0;
          r_shift <= {UART_STOP_BIT, r_shift[UART_FRAME_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
            r_active <= 1'b0;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end else begin
          r_baud <= r_baud + BAUD_W'(1);
        end
        // Registered one cycle early so the pulse lands on the last stop-bit cycle.
        if ((r_baud == BAUD_PRE) && (r_bit == BIT_LAST)) begin
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign TX         = r_shift[0];
  assign frame_done = r_frame_done;

endmodule

// File: rtl/uart_msg_tx.sv
// Message sequencer: reads msg_len bytes from BRAM at TXSTR_BASE and sends them as UART frames.
// Define UART_MSG_TX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LEN          = 256,
  parameter int unsigned TXSTR_BASE   = LEN / 2,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_W       = $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_valid,
  input  logic [ADDR_W-1:0] msg_len,
  output logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  dout,
  output logic              busy,
  output logic              done,
  output logic              TX
);

  uart_tx_state_t    r_state;
  uart_tx_state_t    w_state_nxt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] w_len_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_ser_start;
  logic              w_frame_done;
  logic              w_tx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath updates; addr only moves on entry to FETCH.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      IDLE: begin
        if (msg_valid) begin
          w_len_nxt   = msg_len;
          w_idx_nxt   = '0;
          w_state_nxt = (msg_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: w_state_nxt = LOAD;
      LOAD:  w_state_nxt = SEND;
      SEND: begin
        if (w_frame_done) begin
          w_idx_nxt   = r_idx + ADDR_W'(1);
          w_state_nxt = (w_idx_nxt == r_len) ? DONE : FETCH;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == FETCH) begin
      w_addr_nxt = ADDR_W'(TXSTR_BASE) + w_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_addr <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_len  <= w_len_nxt;
      r_idx  <= w_idx_nxt;
      r_addr <= w_addr_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // BRAM data is valid in LOAD, one cycle after addr was presented in FETCH.
  assign w_ser_start = (r_state == LOAD);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_ser_start),
    .data      (UART_DATA_W'(dout)),
    .TX        (w_tx),
    .frame_done(w_frame_done)
  );

  assign addr = r_addr;
  assign busy = r_busy;
  assign done = r_done;
  assign TX   = w_tx;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: per-cycle expected timeline per instance plus literal spot checks.
module tb_uart_msg_tx;

  localparam int unsigned CPB  = 4;
  localparam int unsigned FB   = uart_pkg::UART_FRAME_BITS;
  localparam int unsigned P    = 2 + FB * CPB;
  localparam int          MAXC = 2048;

  logic       clk;
  logic       rst_n_a     [2];
  logic       msg_valid_a [2];
  logic [7:0] msg_len_a   [2];
  logic [7:0] addr_a      [2];
  logic [7:0] dout_a      [2];
  logic       busy_a      [2];
  logic       done_a      [2];
  logic       tx_a        [2];

  logic [7:0] bram [256];
  int         base_a [2];

  bit         exp_tx   [2][MAXC];
  bit         exp_busy [2][MAXC];
  bit         exp_done [2][MAXC];
  logic [7:0] exp_addr [2][MAXC];

  int cyc;
  int errors;
  int checks;
  bit chk_en;

  uart_msg_tx #(.CLKS_PER_BIT(CPB)) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .msg_valid(msg_valid_a[0]), .msg_len(msg_len_a[0]),
    .addr(addr_a[0]), .dout(dout_a[0]), .busy(busy_a[0]), .done(done_a[0]), .TX(tx_a[0])
  );

  uart_msg_tx #(.CLKS_PER_BIT(CPB), .TXSTR_BASE(250)) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .msg_valid(msg_valid_a[1]), .msg_len(msg_len_a[1]),
    .addr(addr_a[1]), .dout(dout_a[1]), .busy(busy_a[1]), .done(done_a[1]), .TX(tx_a[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    dout_a[0] <= bram[addr_a[0]];
    dout_a[1] <= bram[addr_a[1]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FB == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // Expected outputs of instance i for a message of n bytes accepted in cycle t.
  task automatic model_msg(input int i, input int t, input int n);
    int         f;
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      a = 8'((base_a[i] + k) % 256);
      b = bram[a];
      f = t + 1 + k * P;
      for (int c = f; c < MAXC; c++) exp_addr[i][c] = a;
      for (int j = 0; j < FB; j++)
        for (int c = 0; c < CPB; c++)
          if (f + 2 + j * CPB + c < MAXC) exp_tx[i][f + 2 + j * CPB + c] = frame_bit(b, j);
    end
    d = t + 1 + n * P;
    for (int c = t + 1; c <= d && c < MAXC; c++) exp_busy[i][c] = 1'b1;
    if (d < MAXC) exp_done[i][d] = 1'b1;
  endtask

  // Reset sampled at the end of cycle r: idle outputs from r+1 onward.
  task automatic model_reset(input int i, input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      exp_tx[i][c]   = 1'b1;
      exp_busy[i][c] = 1'b0;
      exp_done[i][c] = 1'b0;
      exp_addr[i][c] = 8'h00;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx%0d", i),   32'(tx_a[i]),   32'(exp_tx[i][cyc]));
        chk($sformatf("busy%0d", i), 32'(busy_a[i]), 32'(exp_busy[i][cyc]));
        chk($sformatf("done%0d", i), 32'(done_a[i]), 32'(exp_done[i][cyc]));
        chk($sformatf("addr%0d", i), 32'(addr_a[i]), 32'(exp_addr[i][cyc]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start(input int i, input int n);
    msg_valid_a[i] = 1'b1;
    msg_len_a[i]   = 8'(n);
    model_msg(i, cyc, n);
    step();
    msg_valid_a[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int d;
    cyc    = 0;
    errors = 0;
    checks = 0;
    chk_en = 1'b0;
    base_a[0] = 128;
    base_a[1] = 250;
    for (int i = 0; i < 256; i++) bram[i] = 8'(i * 29 + 7);
    bram[128] = 8'h41;
    bram[129] = 8'h42;
    bram[251] = 8'h43;
    for (int i = 0; i < 2; i++) begin
      rst_n_a[i]     = 1'b0;
      msg_valid_a[i] = 1'b0;
      msg_len_a[i]   = 8'h00;
      for (int c = 0; c < MAXC; c++) begin
        exp_tx[i][c]   = 1'b1;
        exp_busy[i][c] = 1'b0;
        exp_done[i][c] = 1'b0;
        exp_addr[i][c] = 8'h00;
      end
    end

    repeat (3) step();
    rst_n_a[0] = 1'b1;
    rst_n_a[1] = 1'b1;
    chk_en     = 1'b1;
    chk("rst_tx",   32'(tx_a[0]),   32'd1);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_done", 32'(done_a[0]), 32'd0);
    chk("rst_addr", 32'(addr_a[0]), 32'd0);
    step();

    // Two bytes 0x41, 0x42 from address 128.
    t = cyc;
    start(0, 2);
    wait_until(t + 1);  chk("lit_addr0", 32'(addr_a[0]), 32'd128);
    wait_until(t + 2);  chk("lit_busy",  32'(busy_a[0]), 32'd1);
    wait_until(t + 3);  chk("lit_start", 32'(tx_a[0]),   32'd0);
    wait_until(t + 7);  chk("lit_d0",    32'(tx_a[0]),   32'd1);
    wait_until(t + 11); chk("lit_d1",    32'(tx_a[0]),   32'd0);
    wait_until(t + 39);
`ifdef UART_MSG_TX_PARITY_EN
    chk("lit_par41", 32'(tx_a[0]), 32'd0);
`else
    chk("lit_stop",  32'(tx_a[0]), 32'd1);
`endif
    wait_until(t + 1 + P);     chk("lit_addr1", 32'(addr_a[0]), 32'd129);
    wait_until(t + 1 + P + 1); chk("lit_gap",   32'(tx_a[0]),   32'd1);
    wait_until(t + 3 + P);     chk("lit_start1", 32'(tx_a[0]),  32'd0);
    wait_until(t + 7 + P);     chk("lit_b1d0",  32'(tx_a[0]),   32'd0);
    wait_until(t + 11 + P);    chk("lit_b1d1",  32'(tx_a[0]),   32'd1);
    d = t + 1 + 2 * P;
    wait_until(d - 1); chk("lit_nodone", 32'(done_a[0]), 32'd0);
    wait_until(d);     chk("lit_done",   32'(done_a[0]), 32'd1);
    repeat (3) step();

    // Zero-length message.
    t = cyc;
    start(0, 0);
    chk("lit_len0_done", 32'(done_a[0]), 32'd1);
    chk("lit_len0_busy", 32'(busy_a[0]), 32'd1);
    chk("lit_len0_addr", 32'(addr_a[0]), 32'd129);
    step();
    chk("lit_len0_idle", 32'(busy_a[0]), 32'd0);
    repeat (2) step();

    // Requests while busy and on the done cycle are dropped.
    t = cyc;
    start(0, 2);
    wait_until(t + 20);
    msg_valid_a[0] = 1'b1;
    msg_len_a[0]   = 8'd5;
    step();
    msg_valid_a[0] = 1'b0;
    d = t + 1 + 2 * P;
    wait_until(d);
    msg_valid_a[0] = 1'b1;
    msg_len_a[0]   = 8'd1;
    step();
    msg_valid_a[0] = 1'b0;
    chk("lit_drop_busy", 32'(busy_a[0]), 32'd0);
    repeat (3) step();

    // Reset during data bit 3 of the first byte.
    t = cyc;
    start(0, 2);
    wait_until(t + 20);
    rst_n_a[0] = 1'b0;
    model_reset(0, cyc);
    step();
    rst_n_a[0] = 1'b1;
    chk("lit_rst_tx",   32'(tx_a[0]),   32'd1);
    chk("lit_rst_busy", 32'(busy_a[0]), 32'd0);
    wait_until(t + 2 * P + 10);
    t = cyc;
    start(0, 1);
    wait_until(t + 3); chk("lit_after_rst", 32'(tx_a[0]), 32'd0);
    wait_until(t + 1 + P); chk("lit_after_done", 32'(done_a[0]), 32'd1);
    repeat (3) step();

    // Ten bytes from base 250 wrap through 255 to 0..3.
    t = cyc;
    start(1, 10);
    wait_until(t + 1);         chk("lit_w_addr0", 32'(addr_a[1]), 32'd250);
    wait_until(t + 1 + 5 * P); chk("lit_w_addr5", 32'(addr_a[1]), 32'd255);
    wait_until(t + 1 + 6 * P); chk("lit_w_addr6", 32'(addr_a[1]), 32'd0);
    wait_until(t + 1 + 9 * P); chk("lit_w_addr9", 32'(addr_a[1]), 32'd3);
    wait_until(t + 1 + 10 * P); chk("lit_w_done", 32'(done_a[1]), 32'd1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
